// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch unit and its sub-blocks.
//   - PC-source select encodings driven by the control unit
//   - phase numbers of the 8-cycle instruction window
//   - opcode field geometry
//   - run/halt state type of the fetch unit
package cpu_pkg;

    // PC-source select encodings (values 5..7 are illegal)
    localparam logic [2:0] PCSEL_JABS = 3'd0;
    localparam logic [2:0] PCSEL_BR   = 3'd1;
    localparam logic [2:0] PCSEL_JREG = 3'd2;
    localparam logic [2:0] PCSEL_INC  = 3'd3;
    localparam logic [2:0] PCSEL_HALT = 3'd4;

    // Window phases with a dedicated action on the edge that ends them
    localparam int         PHASE_W    = 3;
    localparam logic [2:0] PH_NEXTPC  = 3'd4;
    localparam logic [2:0] PH_FETCH   = 3'd5;
    localparam logic [2:0] PH_LOAD    = 3'd6;
    localparam logic [2:0] PH_DECODE  = 3'd7;

    // Opcode occupies the top OPC_W bits of the instruction word
    localparam int         OPC_W      = 6;

    typedef enum logic {
        RUN_ST  = 1'b0,
        HALT_ST = 1'b1
    } run_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bundles the instruction-memory, control-unit and datapath
// signals of the fetch unit.
//   slave  modport: the fetch unit (drives im_addr, instr, opcode, pc, phase,
//                   decode_en, halted, illegal_sel)
//   master modport: surrounding system (drives im_rdata, pc_sel, br_lt, equ,
//                   les, reg_target)
// Timing contract (no valid/ready handshake): the unit is phase-scheduled.
// im_rdata must be valid for the im_addr presented one cycle earlier;
// pc_sel/br_lt/equ/les/reg_target are only sampled on the clock edge ending
// phase 4 and are don't-care at every other edge.
interface pc_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_rdata;
    logic [2:0]         pc_sel;
    logic               br_lt;
    logic               equ;
    logic               les;
    logic [ADDR_W-1:0]  reg_target;
    logic [INSTR_W-1:0] instr;
    logic [OPC_W-1:0]   opcode;
    logic [ADDR_W-1:0]  pc;
    logic [PHASE_W-1:0] phase;
    logic               decode_en;
    logic               halted;
    logic               illegal_sel;

    modport slave (
        output im_addr, instr, opcode, pc, phase, decode_en, halted, illegal_sel,
        input  im_rdata, pc_sel, br_lt, equ, les, reg_target
    );

    modport master (
        input  im_addr, instr, opcode, pc, phase, decode_en, halted, illegal_sel,
        output im_rdata, pc_sel, br_lt, equ, les, reg_target
    );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection and branch decision.
//   pc          current PC
//   jabs_target absolute jump target (low ADDR_W bits of the instruction)
//   br_off      signed branch offset field of the instruction
//   pc_sel      PC-source select from the control unit
//   br_lt/equ/les  branch kind and ALU flags
//   reg_target  register-file value for jump register
//   pc_next     selected next PC (all arithmetic wraps modulo 2^ADDR_W)
//   halt_req    pc_sel requests halt
//   illegal_req pc_sel is an unused encoding
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int OFF_W  = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] jabs_target,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [2:0]        pc_sel,
    input  logic              br_lt,
    input  logic              equ,
    input  logic              les,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic              halt_req,
    output logic              illegal_req
);
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off_ext;
    logic              taken;

    always_comb begin
        pc_inc      = pc + ADDR_W'(1);
        // Sign-extend (or truncate) the offset field to the PC width
        off_ext     = ADDR_W'($signed(br_off));
        taken       = br_lt ? les : equ;
        pc_next     = pc_inc;
        halt_req    = 1'b0;
        illegal_req = 1'b0;
        case (pc_sel)
            PCSEL_JABS: pc_next = jabs_target;
            PCSEL_BR:   pc_next = taken ? (pc_inc + off_ext) : pc_inc;
            PCSEL_JREG: pc_next = reg_target;
            PCSEL_INC:  pc_next = pc_inc;
            PCSEL_HALT: begin
                pc_next  = pc;
                halt_req = 1'b1;
            end
            // Unused encodings still advance sequentially so the program
            // keeps running while the sticky flag records the fault
            default:    illegal_req = 1'b1;
        endcase
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC and fetches one instruction per 8-cycle window.
//   clk, rst  system clock, synchronous active-high reset
//   bus       pc_fetch_unit_if.slave (memory address/data, control-unit
//             select and flags, instruction/opcode/pc/phase/status outputs)
// Window schedule (action on the edge ending the phase):
//   phase 4: next PC computed from pc_sel/flags
//   phase 5: im_addr <= pc
//   phase 6: instr <= im_rdata
//   phase 7: decode_en high; control unit decodes on this edge
// Reset lands at phase 5 so the first fetch from RESET_PC follows naturally.
// The interface instance must use the same ADDR_W/INSTR_W as this module.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter int               INSTR_W  = 32,
    parameter int               OFF_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.slave bus
);
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    run_state_e         state_q, state_d;
    logic               illegal_q, illegal_d;

    logic [ADDR_W-1:0]  pc_next;
    logic               halt_req;
    logic               illegal_req;

    pc_next_calc #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_next (
        .pc          (pc_q),
        .jabs_target (instr_q[ADDR_W-1:0]),
        .br_off      (instr_q[OFF_W-1:0]),
        .pc_sel      (bus.pc_sel),
        .br_lt       (bus.br_lt),
        .equ         (bus.equ),
        .les         (bus.les),
        .reg_target  (bus.reg_target),
        .pc_next     (pc_next),
        .halt_req    (halt_req),
        .illegal_req (illegal_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            im_addr_q <= RESET_PC;
            instr_q   <= '0;
            phase_q   <= PH_FETCH;
            state_q   <= RUN_ST;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            im_addr_q <= im_addr_d;
            instr_q   <= instr_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        im_addr_d = im_addr_q;
        instr_d   = instr_q;
        phase_d   = phase_q;
        state_d   = state_q;
        illegal_d = illegal_q;
        // Halted freezes everything; only rst leaves HALT_ST
        if (state_q == RUN_ST) begin
            phase_d = phase_q + PHASE_W'(1);
            case (phase_q)
                PH_NEXTPC: begin
                    pc_d = pc_next;
                    if (halt_req)    state_d   = HALT_ST;
                    if (illegal_req) illegal_d = 1'b1;
                end
                PH_FETCH: im_addr_d = pc_q;
                PH_LOAD:  instr_d   = bus.im_rdata;
                default: ;
            endcase
        end
    end

    assign bus.im_addr     = im_addr_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: OPC_W];
    assign bus.pc          = pc_q;
    assign bus.phase       = phase_q;
    assign bus.decode_en   = (state_q == RUN_ST) && (phase_q == PH_DECODE);
    assign bus.halted      = (state_q == HALT_ST);
    assign bus.illegal_sel = illegal_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized + directed bench for pc_fetch_unit with an
// instruction-level reference model and literal spot checks.
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) bus();

    pc_fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (32),
        .OFF_W    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: combinational read of the registered address
    logic [31:0] mem [0:65535];
    assign bus.im_rdata = mem[bus.im_addr];

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // ---------------- reference model ----------------
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    logic [31:0] m_instr;
    int          m_phase = 0;
    bit          m_halted;
    bit          m_ill;

    function automatic logic [15:0] model_next_pc(input logic [15:0] pc,
                                                  input logic [31:0] ins,
                                                  input int sel, input bit lt,
                                                  input bit e, input bit l,
                                                  input logic [15:0] rt);
        int off;
        int target;
        off = int'($signed(ins[15:0]));
        if (sel == 0)      target = int'(ins[15:0]);
        else if (sel == 1) target = (lt ? l : e) ? int'(pc) + 1 + off : int'(pc) + 1;
        else if (sel == 2) target = int'(rt);
        else if (sel == 4) target = int'(pc);
        else               target = int'(pc) + 1;
        return 16'(target);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc     <= 16'h0000;
            m_addr   <= 16'h0000;
            m_instr  <= 32'h0;
            m_phase  <= 5;
            m_halted <= 1'b0;
            m_ill    <= 1'b0;
            check_en <= 1'b1;
        end else if (!m_halted) begin
            if (m_phase == 4) begin
                m_pc <= model_next_pc(m_pc, m_instr, int'(bus.pc_sel), bus.br_lt,
                                      bus.equ, bus.les, bus.reg_target);
                if (bus.pc_sel == 3'd4) m_halted <= 1'b1;
                if (bus.pc_sel > 3'd4)  m_ill    <= 1'b1;
            end
            if (m_phase == 5) m_addr  <= m_pc;
            if (m_phase == 6) m_instr <= mem[m_addr];
            m_phase <= (m_phase + 1) % 8;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc",          32'(bus.pc),          32'(m_pc));
            chk("im_addr",     32'(bus.im_addr),     32'(m_addr));
            chk("instr",       bus.instr,            m_instr);
            chk("opcode",      32'(bus.opcode),      32'(m_instr[31:26]));
            chk("phase",       32'(bus.phase),       32'(m_phase));
            chk("decode_en",   32'(bus.decode_en),   32'((m_phase == 7) && !m_halted));
            chk("halted",      32'(bus.halted),      32'(m_halted));
            chk("illegal_sel", 32'(bus.illegal_sel), 32'(m_ill));
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_junk();
        bus.pc_sel     = 3'($urandom_range(0, 7));
        // Keep stray halts/illegals out of any phase-4 edge we did not plan
        if (m_phase == 4) bus.pc_sel = 3'd3;
        bus.br_lt      = 1'($urandom_range(0, 1));
        bus.equ        = 1'($urandom_range(0, 1));
        bus.les        = 1'($urandom_range(0, 1));
        bus.reg_target = 16'($urandom());
    endtask

    // Present the given select/flags during phase 4, then step past that edge
    task automatic window(input logic [2:0] sel, input bit lt, input bit e,
                          input bit l, input logic [15:0] rt);
        bit done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            @(negedge clk);
            if (m_phase == 4 && !m_halted) begin
                bus.pc_sel     = sel;
                bus.br_lt      = lt;
                bus.equ        = e;
                bus.les        = l;
                bus.reg_target = rt;
                done = 1'b1;
            end else begin
                drive_junk();
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL window_timeout: got no phase 4 expected phase 4 within 16 cycles");
        end
        @(negedge clk);
        drive_junk();
    endtask

    task automatic random_window();
        int v;
        v = $urandom_range(0, 6);
        window(3'(v < 4 ? v : v + 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 16'($urandom()));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"},      32'(bus.pc),          32'h0);
        chk({tag, "_phase"},   32'(bus.phase),       32'd5);
        chk({tag, "_halted"},  32'(bus.halted),      32'd0);
        chk({tag, "_illegal"}, 32'(bus.illegal_sel), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] frozen_pc;
        bit reached;
        for (int a = 0; a < 65536; a++) mem[a] = $urandom();
        for (int a = 0; a < 3; a++) mem[a] = 32'h0400_0000 | 32'(a);
        mem[3]      = 32'h0400_0040;
        mem[16'h1234] = 32'h0000_0010;
        mem[16'h0010] = 32'h0000_FFFE;
        mem[16'h000F] = 32'h0000_0010;
        mem[16'h0011] = 32'h0000_0010;
        mem[16'h0016] = 32'h0000_FFFF;

        drive_junk();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        chk("reset_im_addr", 32'(bus.im_addr), 32'h0);
        chk("reset_instr",   bus.instr,        32'h0);
        rst = 1'b0;

        // First fetch from RESET_PC, decode at phase 7
        repeat (2) @(negedge clk);
        chk("first_decode_en", 32'(bus.decode_en), 32'd1);
        chk("first_opcode",    32'(bus.opcode),    32'd1);

        // Sequential flow
        for (int k = 1; k <= 3; k++) begin
            window(3'd3, 1'b0, 1'b0, 1'b0, 16'h0);
            chk("seq_pc", 32'(bus.pc), 32'(k));
            @(negedge clk);
            chk("seq_im_addr", 32'(bus.im_addr), 32'(k));
        end
        mem[2] = 32'h0000_FFF0;

        window(3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("jabs_pc", 32'(bus.pc), 32'h0040);
        window(3'd2, 1'b0, 1'b0, 1'b0, 16'h1234);
        chk("jreg_pc", 32'(bus.pc), 32'h1234);
        window(3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("jabs2_pc", 32'(bus.pc), 32'h0010);
        window(3'd1, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("beq_taken_pc", 32'(bus.pc), 32'h000F);
        window(3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        window(3'd1, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("beq_not_taken_pc", 32'(bus.pc), 32'h0011);
        mem[16'h0010] = 32'h0000_0005;
        window(3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        window(3'd1, 1'b1, 1'b0, 1'b1, 16'h0);
        chk("blt_taken_pc", 32'(bus.pc), 32'h0016);
        window(3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("to_ffff_pc", 32'(bus.pc), 32'hFFFF);
        window(3'd3, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap_inc_pc", 32'(bus.pc), 32'h0000);
        window(3'd2, 1'b0, 1'b0, 1'b0, 16'h0002);
        window(3'd1, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("wrap_branch_pc", 32'(bus.pc), 32'hFFF3);
        window(3'd6, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("illegal_pc",  32'(bus.pc),          32'hFFF4);
        chk("illegal_set", 32'(bus.illegal_sel), 32'd1);

        repeat (25) random_window();
        chk("illegal_sticky", 32'(bus.illegal_sel), 32'd1);

        // Reset mid-window at phase 2
        reached = 1'b0;
        for (int k = 0; k < 16 && !reached; k++) begin
            @(negedge clk);
            drive_junk();
            if (m_phase == 2) reached = 1'b1;
        end
        chk("reach_phase2", 32'(reached), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_mid");
        rst = 1'b0;

        repeat (10) random_window();

        // Halt and freeze
        window(3'd4, 1'b0, 1'b0, 1'b0, 16'h0);
        frozen_pc = m_pc;
        chk("halt_set", 32'(bus.halted), 32'd1);
        repeat (20) begin
            @(negedge clk);
            drive_junk();
        end
        chk("halt_pc_frozen",  32'(bus.pc),        32'(frozen_pc));
        chk("halt_phase",      32'(bus.phase),     32'd5);
        chk("halt_decode_off", 32'(bus.decode_en), 32'd0);
        chk("halt_still",      32'(bus.halted),    32'd1);

        // Reset while halted
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_halt");
        rst = 1'b0;
        repeat (4) random_window();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-side counterpart of the multi-cycle control unit.
- Owns the PC, fetches one instruction word per 8-cycle instruction window, and presents the opcode to the control unit.
- Consumes the control unit's PC-source select (sel[2:0]) and the ALU flags equ/les to compute the next PC.
- Sits between instruction memory and the control unit / datapath.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 32, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-6].
- OFF_W, 16, signed branch offset field width, bits [OFF_W-1:0] of the instruction.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- im_addr  out  ADDR_W  instruction memory address (registered)
- im_rdata  in  INSTR_W  instruction memory read data, valid one cycle after im_addr
- pc_sel  in  3  PC source from the control unit: 0 jump absolute, 1 conditional branch, 2 jump register, 3 PC+1, 4 halt, 5-7 illegal
- br_lt  in  1  branch kind for pc_sel=1: 0 = branch-if-equal (uses equ), 1 = branch-if-less (uses les); driven from opcode bit 0
- equ  in  1  ALU equal flag
- les  in  1  ALU less-than flag
- reg_target  in  ADDR_W  register-file value for jump register
- instr  out  INSTR_W  instruction register
- opcode  out  6  instr top 6 bits, to control unit
- pc  out  ADDR_W  current PC
- phase  out  3  window phase counter
- decode_en  out  1  high while phase==7; the control unit decodes on the edge ending this phase
- halted  out  1  sticky halt flag
- illegal_sel  out  1  sticky flag for pc_sel in 5..7

Behaviour:
- Reset (rst high at a clk edge) sets: pc=RESET_PC, im_addr=RESET_PC, instr=0, phase=5, halted=0, illegal_sel=0. Reset has priority over all other activity, including mid-window and while halted.
- Phase counts 0..7 and wraps 7->0, advancing by 1 on every edge unless halted.
- Edge ending phase 4 (next-PC update). pc_sel and flags are sampled here:
  - 0: pc <= instr[ADDR_W-1:0]
  - 1: if (br_lt ? les : equ), pc <= pc + 1 + sext(instr[OFF_W-1:0]); otherwise pc <= pc + 1
  - 2: pc <= reg_target
  - 3: pc <= pc + 1
  - 4: pc holds; halted <= 1
  - 5-7: pc <= pc + 1; illegal_sel <= 1
- All PC arithmetic is modulo 2^ADDR_W (wraps silently). The sign-extended offset is truncated or extended to ADDR_W.
- Edge ending phase 5: im_addr <= pc.
- Edge ending phase 6: instr <= im_rdata, so opcode is stable from phase 7 through phase 6 of the next window.
- After reset, the first fetch is from RESET_PC: im_addr is already valid, and instr loads at the edge ending phase 6. The first decode_en pulse follows at phase 7.
- Halted state:
  - phase, pc, im_addr and instr freeze.
  - decode_en stays 0.
  - Only rst exits.
- Outputs change only on clk edges; no combinational paths from inputs to outputs, except that opcode is a slice of instr.
- equ/les/reg_target/pc_sel are ignored outside the phase-4 edge.

Decomposition:
- Shared package cpu_pkg holds:
  - PC-source encodings PCSEL_JABS=0, PCSEL_BR=1, PCSEL_JREG=2, PCSEL_INC=3, PCSEL_HALT=4
  - phase constants PH_NEXTPC=4, PH_FETCH=5, PH_LOAD=6, PH_DECODE=7
  - opcode field position constants
- One natural sub-module, pc_next_calc: the combinational next-PC/branch-decision mux, unit-testable alone.

Test Plan:
- Sequential flow: reset, pc_sel=3 every window, im_rdata = 0x04000000 | addr -> im_addr steps 0,1,2,3 at 8-cycle spacing; opcode=1 presented with decode_en at phase 7.
- Jump absolute: window at pc=3, instr low bits 0x0040, pc_sel=0 -> next im_addr=0x0040; jump register with reg_target=0x1234, pc_sel=2 -> im_addr=0x1234.
- Branches: pc=0x0010, offset 0xFFFE, br_lt=0, equ=1 -> pc=0x000F; same with equ=0 -> 0x0011; br_lt=1, les=1, offset 0x0005 -> 0x0016.
- Wrap: pc=0xFFFF, pc_sel=3 -> pc=0x0000; pc=0x0002, offset 0xFFF0 taken -> 0xFFF3.
- Halt and illegal: pc_sel=4 at the phase-4 edge -> halted=1; phase, pc and instr frozen for 20 cycles; decode_en=0. pc_sel=6 -> illegal_sel=1 sticky, pc=pc+1.
- Reset mid-window: assert rst at phase 2, and again while halted -> pc=RESET_PC, phase=5, halted=0, illegal_sel=0 on the following cycle.
